capture_read_sequencer: RTL
===========================

// Module: capture_read_sequencer
// PURPOSE
//   Sequences one still-frame capture and its HPS readout. On an HPS start request it runs
//   the D5M capture path for SETTLE_FRAMES frames, stops the camera and reloads the SDRAM read FIFOs.
//   It then moves the read port from VGA to HPS and serves pixels over a 4-phase req/ack handshake.
//   It replaces the free-running PIO read clock and the manual source_select/cam_start control.
// PARAMETERS
//   SETTLE_FRAMES  2       frames captured after start before stopping (1..15)
//   PIXELS         76800   reads per frame (320*240); read FIFO depth cycle length
//   RD_LAT         2       iCLK cycles from oRd pulse to valid iRd_DATA
//   LOAD_CYC       4       cycles oRd_Load held high to reset the read FIFOs/address
//   DATA_W         16      SDRAM read data width
// PORTS
//   iCLK         in   1       system clock (same clock that drives the SDRAM read-FIFO side)
//   iRST_N       in   1       async active-low reset
//   iStart       in   1       HPS start request, level; rising edge (post-sync) starts a capture
//   iAbort       in   1       HPS abort, level; high forces return to IDLE
//   iFVAL        in   1       CCD frame valid, pixel-clock domain; 2-flop synced internally
//   iHps_Req     in   1       HPS pixel request, 4-phase; 2-flop synced internally
//   iRd_DATA     in   DATA_W  read-FIFO output data
//   oCam_Start   out  1       to CCD_Capture iSTART (iEND driven by its inverse at top level)
//   oSource_Sel  out  1       0 = VGA owns read port/clock, 1 = sequencer owns it
//   oRd          out  1       read strobe to SDRAM read FIFOs (muxed at top level by oSource_Sel)
//   oRd_Load     out  1       read-FIFO load/flush (ORed with reset at top level)
//   oData        out  DATA_W  latched pixel for HPS, valid while oAck=1
//   oAck         out  1       handshake acknowledge
//   oBusy        out  1       high in every state except IDLE and DONE
//   oDone        out  1       high in DONE
//   oPix_Cnt     out  17      pixels delivered in the current readout
//   oState       out  3       state encoding for HPS debug
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, counters 0, sync flops 0. Reset mid-operation aborts immediately.
//   States (oState): IDLE=0 ARM=1 STOP=2 LOAD=3 WAIT=4 FETCH=5 ACK=6 DONE=7.
//   IDLE: oSource_Sel=0, oCam_Start=0. A rising edge of synced iStart -> ARM, frame_cnt=0.
//   ARM: oCam_Start=1. Each falling edge of synced FVAL increments frame_cnt. When frame_cnt
//     reaches SETTLE_FRAMES -> STOP, and oCam_Start drops on that transition.
//   STOP: wait until synced FVAL=0 (already low, so 1 cycle). Then -> LOAD with load_cnt=0.
//   LOAD: oSource_Sel=1, oRd_Load=1 for exactly LOAD_CYC cycles, then -> WAIT with oPix_Cnt=0.
//   WAIT: oAck=0. Synced iHps_Req=1 -> FETCH. iHps_Req high on entry counts as a request.
//   FETCH: oRd=1 on the first cycle only, then count RD_LAT cycles. On the last count,
//     oData<=iRd_DATA, oAck<=1 -> ACK.
//   ACK: hold oAck and oData. Synced iHps_Req=0 -> oAck<=0, oPix_Cnt+1.
//     If the new count == PIXELS -> DONE, else -> WAIT.
//   DONE: oDone=1, oSource_Sel=1, oData held. Synced iStart low -> IDLE; the HPS must drop iStart to release.
//   iAbort (synced) =1 in any state: next cycle -> IDLE. oCam_Start, oRd, oAck, oRd_Load,
//     oSource_Sel all 0. oPix_Cnt holds its value. iAbort has priority over all transitions.
//   An iStart edge outside IDLE is ignored. No restart from DONE without iStart low then high.
//   oRd never asserts unless oSource_Sel=1. At most one oRd per handshake.
//   oRd is never asserted during oRd_Load.
//   Request-to-ack latency: 2 (sync) + 1 + RD_LAT cycles. Ack drop: 2 sync + 1 cycles.
//   oPix_Cnt saturates at PIXELS. It never wraps.
// TESTING
//   1 Reset: hold iRST_N=0 with random inputs -> all outputs 0, oState=0. Release -> stays IDLE.
//   2 Capture: iStart 0->1, then 2 FVAL pulses -> oCam_Start 1 until the 2nd FVAL fall.
//     Then oRd_Load high exactly 4 cycles, oSource_Sel=1, oState=4.
//   3 Handshake: model FIFO returning 16'hA5A5 RD_LAT=2 cycles after oRd. Request ->
//     oAck after 5 cycles, oData=16'hA5A5, one oRd pulse. Drop request -> oAck=0, oPix_Cnt=1.
//   4 Full frame with PIXELS=8 override: 8 handshakes -> oDone=1, oState=7.
//     A 9th request gives no oRd. iStart low -> IDLE, oSource_Sel=0.
//   5 Abort: iAbort high in ARM, and again in FETCH -> IDLE next cycle after sync, oCam_Start=0,
//     oRd=0. Pulse iStart during FETCH -> no effect.
//   6 Reset mid-readout: iRST_N low in ACK with oPix_Cnt=3 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/capture_read_sequencer.sv
// Sequences one still-frame capture, then serves the frame to the HPS
// pixel by pixel over a synchronized 4-phase req/ack handshake.
//
// Ports:
//   iCLK, iRST_N            clock, async active-low reset
//   iStart, iAbort          HPS control levels (synced here)
//   iFVAL                   CCD frame valid (synced here)
//   iHps_Req                HPS pixel request (synced here)
//   iRd_DATA                SDRAM read-FIFO data
//   oCam_Start              CCD capture enable
//   oSource_Sel             1 = sequencer owns the read port
//   oRd, oRd_Load           read strobe, FIFO load/flush
//   oData, oAck             pixel and acknowledge to HPS
//   oBusy, oDone            status
//   oPix_Cnt, oState        debug/progress
module capture_read_sequencer #(
  parameter int SETTLE_FRAMES = 2,
  parameter int PIXELS        = 76800,
  parameter int RD_LAT        = 2,
  parameter int LOAD_CYC      = 4,
  parameter int DATA_W        = 16
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iFVAL,
  input  logic              iHps_Req,
  input  logic [DATA_W-1:0] iRd_DATA,
  output logic              oCam_Start,
  output logic              oSource_Sel,
  output logic              oRd,
  output logic              oRd_Load,
  output logic [DATA_W-1:0] oData,
  output logic              oAck,
  output logic              oBusy,
  output logic              oDone,
  output logic [16:0]       oPix_Cnt,
  output logic [2:0]        oState
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    STOP  = 3'd2,
    LOAD  = 3'd3,
    WAIT  = 3'd4,
    FETCH = 3'd5,
    ACK   = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam logic [3:0]  SETTLE_L = 4'(SETTLE_FRAMES);
  localparam logic [7:0]  LOAD_L   = 8'(LOAD_CYC - 1);
  localparam logic [7:0]  LAT_L    = 8'(RD_LAT - 1);
  localparam logic [16:0] PIX_L    = 17'(PIXELS);

  state_t      state;
  logic [3:0]  frame_cnt;
  logic [7:0]  load_cnt;
  logic [7:0]  lat_cnt;
  logic [16:0] pix_next;

  logic start_m, start_s, start_q;
  logic fval_m, fval_s, fval_q;
  logic req_m, req_s;
  logic abort_m, abort_s;
  logic start_rise, fval_fall;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      start_m <= 1'b0;
      start_s <= 1'b0;
      start_q <= 1'b0;
      fval_m  <= 1'b0;
      fval_s  <= 1'b0;
      fval_q  <= 1'b0;
      req_m   <= 1'b0;
      req_s   <= 1'b0;
      abort_m <= 1'b0;
      abort_s <= 1'b0;
    end else begin
      start_m <= iStart;
      start_s <= start_m;
      start_q <= start_s;
      fval_m  <= iFVAL;
      fval_s  <= fval_m;
      fval_q  <= fval_s;
      req_m   <= iHps_Req;
      req_s   <= req_m;
      abort_m <= iAbort;
      abort_s <= abort_m;
    end
  end

  assign start_rise = start_s & ~start_q;
  assign fval_fall  = ~fval_s & fval_q;

  // Count sticks at PIXELS rather than wrapping.
  assign pix_next = (oPix_Cnt == PIX_L) ?
                    oPix_Cnt : oPix_Cnt + 17'd1;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      load_cnt   <= '0;
      lat_cnt    <= '0;
      oCam_Start <= 1'b0;
      oRd        <= 1'b0;
      oRd_Load   <= 1'b0;
      oData      <= '0;
      oAck       <= 1'b0;
      oPix_Cnt   <= '0;
    end else if (abort_s) begin
      state      <= IDLE;
      oCam_Start <= 1'b0;
      oRd        <= 1'b0;
      oRd_Load   <= 1'b0;
      oAck       <= 1'b0;
    end else begin
      oRd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_rise) begin
            state      <= ARM;
            frame_cnt  <= '0;
            oCam_Start <= 1'b1;
          end
        end
        ARM: begin
          if (fval_fall) begin
            frame_cnt <= frame_cnt + 4'd1;
            if (frame_cnt + 4'd1 == SETTLE_L) begin
              state      <= STOP;
              oCam_Start <= 1'b0;
            end
          end
        end
        STOP: begin
          if (!fval_s) begin
            state    <= LOAD;
            load_cnt <= '0;
            oRd_Load <= 1'b1;
          end
        end
        LOAD: begin
          if (load_cnt == LOAD_L) begin
            state    <= WAIT;
            oRd_Load <= 1'b0;
            oPix_Cnt <= '0;
          end else begin
            load_cnt <= load_cnt + 8'd1;
          end
        end
        WAIT: begin
          oAck <= 1'b0;
          if (req_s) begin
            state   <= FETCH;
            lat_cnt <= '0;
            oRd     <= 1'b1;
          end
        end
        FETCH: begin
          if (lat_cnt == LAT_L) begin
            state <= ACK;
            oData <= iRd_DATA;
            oAck  <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        ACK: begin
          if (!req_s) begin
            oAck     <= 1'b0;
            oPix_Cnt <= pix_next;
            state    <= (pix_next == PIX_L) ? DONE : WAIT;
          end
        end
        DONE: begin
          if (!start_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oState      = state;
  assign oBusy       = (state != IDLE) && (state != DONE);
  assign oDone       = (state == DONE);
  assign oSource_Sel = (state == LOAD) || (state == WAIT) ||
                       (state == FETCH) || (state == ACK) ||
                       (state == DONE);

endmodule
